// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 8-point radix-2 FFT datapath.
//   FFT_N       : default samples per frame
//   FFT_LOG2N   : address bits for FFT_N
//   FFT_DATA_W  : default bits per sample
//   bitrev()    : reverses the low log2n bits of an index; used by the input
//                 reorder buffer and by the butterfly network twiddle indexing.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_LOG2N  = 3;
  localparam int FFT_DATA_W = 8;

  // Only the low log2n bits are reversed; everything above stays zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < log2n) begin
        r[i] = idx[log2n - 1 - i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_buf_bank.sv
// -----------------------------------------------------------------------------
// fft_buf_bank
// One N x DATA_W register bank with a single write port and a flattened
// read port exposing every entry at once.
//   clk   : clock
//   rst   : synchronous active-high reset, clears every entry
//   we    : write enable
//   waddr : entry written when we=1
//   wdata : data written
//   rdata : all entries, entry s at bits [DATA_W*(N-s)-1 -: DATA_W]
//           (entry 0 at the MSB end)
// -----------------------------------------------------------------------------
module fft_buf_bank #(
  parameter int DATA_W = 8,
  parameter int N      = 8,
  parameter int AW     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [N*DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_flat
      assign rdata[DATA_W*(N-gi)-1 -: DATA_W] = mem_q[gi];
    end
  endgenerate

endmodule

// File: rtl/fft_bitrev_buffer.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buffer
// Ping-pong input buffer for the FFT. Natural-order samples arrive serially;
// each is written to its bit-reversed slot, so a completed bank already holds
// the frame in FFT input order and is presented in parallel.
//   clk         : clock
//   rst         : synchronous active-high reset
//   in_data     : sample, natural time order
//   in_valid    : in_data valid
//   in_sof      : start of frame, qualified by in_valid && in_ready
//   in_ready    : a sample can be accepted this cycle
//   frame_data  : frame, slot s at bits [DATA_W*(N-s)-1 -: DATA_W]
//   frame_valid : frame_data holds a complete frame
//   frame_ready : consumer takes the frame
//   err_partial : sticky, a frame was cut short by in_sof
// -----------------------------------------------------------------------------
module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N      = FFT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [N*DATA_W-1:0]   frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  err_partial
);

  localparam int LOG2N = $clog2(N);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
  logic             err_q, err_d;

  logic             accept;
  logic             drain;
  logic [LOG2N-1:0] idx_eff;
  logic [LOG2N-1:0] waddr;
  logic [N*DATA_W-1:0] bank_rdata [2];

  assign in_ready = !full_q[wr_bank_q] && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = full_q[rd_bank_q] && frame_ready;

  // A start-of-frame always restarts at index 0; any partial frame is simply
  // overwritten by the new one.
  assign idx_eff = in_sof ? '0 : wr_idx_q;
  assign waddr   = LOG2N'(bitrev(32'(idx_eff), LOG2N));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fft_buf_bank #(
        .DATA_W (DATA_W),
        .N      (N)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (accept && (wr_bank_q == 1'(gi))),
        .waddr (waddr),
        .wdata (in_data),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  assign frame_valid = full_q[rd_bank_q];
  assign frame_data  = bank_rdata[rd_bank_q];
  assign err_partial = err_q;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    err_d     = err_q;

    // Drain and fill always touch different banks, so both can apply.
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (accept) begin
      if (in_sof && (wr_idx_q != '0)) begin
        err_d = 1'b1;
      end
      if (idx_eff == LOG2N'(N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = idx_eff + LOG2N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
module tb_fft_bitrev_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        err_partial;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft_bitrev_buffer #(
    .DATA_W (8),
    .N      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_partial (err_partial)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample and returns 1 ns after the edge that accepted it.
  task automatic push(input logic [7:0] d, input logic sof);
    int w;
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout data=%02h in_ready=%0b required=1", d, in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; frame_ready = 1'b0;
    tick(); tick();
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got=%0b exp=0", frame_valid); end
    n_tests++;
    if (frame_data !== 64'h0) begin n_fail++; $display("FAIL reset_frame_data got=%016h exp=0", frame_data); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    n_tests++;
    if (err_partial !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", err_partial); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    $display("[TB] reset done");
  endtask

  task automatic test_basic_frame();
    frame_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(8'(i), i == 0);
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%0b exp=0", frame_valid); end
    push(8'd7, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0b exp=1", frame_valid); end
    n_tests++;
    if (frame_data !== 64'h0004020601050307) begin n_fail++; $display("FAIL basic_data got=%016h exp=0004020601050307", frame_data); end
    n_tests++;
    if (err_partial !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%0b exp=0", err_partial); end
    tick();
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%0b exp=0", frame_valid); end
    frame_ready = 1'b0;
    $display("[TB] basic frame data=%016h", 64'h0004020601050307);
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b0;
    for (int i = 16; i < 32; i++) push(8'(i), (i % 8) == 0);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got=%0b exp=0", in_ready); end
    n_tests++;
    if (frame_data !== 64'h1014121611151317) begin n_fail++; $display("FAIL bp_frame_a got=%016h exp=1014121611151317", frame_data); end
    tick(); tick(); tick();
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h1014121611151317) begin
      n_fail++; $display("FAIL bp_hold valid=%0b data=%016h exp=1/1014121611151317", frame_valid, frame_data);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_hold got=%0b exp=0", in_ready); end
    frame_ready = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after got=%0b exp=1", in_ready); end
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h181C1A1E191D1B1F) begin
      n_fail++; $display("FAIL bp_frame_b valid=%0b data=%016h exp=1/181C1A1E191D1B1F", frame_valid, frame_data);
    end
    tick();
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%0b exp=0", frame_valid); end
    frame_ready = 1'b0;
    $display("[TB] back-to-back two frames drained");
  endtask

  task automatic test_partial_abort();
    frame_ready = 1'b1;
    push(8'd1, 1'b1); push(8'd2, 1'b0); push(8'd3, 1'b0);
    n_tests++;
    if (err_partial !== 1'b0) begin n_fail++; $display("FAIL partial_err_early got=%0b exp=0", err_partial); end
    push(8'd9, 1'b1);
    n_tests++;
    if (err_partial !== 1'b1) begin n_fail++; $display("FAIL partial_err got=%0b exp=1", err_partial); end
    for (int i = 10; i <= 16; i++) push(8'(i), 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h090D0B0F0A0E0C10) begin
      n_fail++; $display("FAIL partial_frame valid=%0b data=%016h exp=1/090D0B0F0A0E0C10", frame_valid, frame_data);
    end
    tick();
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL partial_extra_frame got=%0b exp=0", frame_valid); end
    frame_ready = 1'b0;
    $display("[TB] partial abort err=%0b", err_partial);
  endtask

  task automatic test_reset_midframe();
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i), i == 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (frame_valid !== 1'b0 || err_partial !== 1'b0 || frame_data !== 64'h0) begin
      n_fail++; $display("FAIL midreset_state valid=%0b err=%0b data=%016h exp=0/0/0", frame_valid, err_partial, frame_data);
    end
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i), i == 0);
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'hA0A4A2A6A1A5A3A7) begin
      n_fail++; $display("FAIL midreset_frame valid=%0b data=%016h exp=1/A0A4A2A6A1A5A3A7", frame_valid, frame_data);
    end
    tick();
    frame_ready = 1'b0;
    $display("[TB] reset mid-frame then clean frame");
  endtask

  task automatic test_simultaneous();
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i), i == 0);
    for (int i = 0; i < 7; i++) push(8'(8'h40 + i), i == 0);
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h3034323631353337) begin
      n_fail++; $display("FAIL sim_first valid=%0b data=%016h exp=1/3034323631353337", frame_valid, frame_data);
    end
    frame_ready = 1'b1;
    push(8'h47, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h4044424641454347) begin
      n_fail++; $display("FAIL sim_second valid=%0b data=%016h exp=1/4044424641454347", frame_valid, frame_data);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sim_in_ready got=%0b exp=1", in_ready); end
    frame_ready = 1'b0;
    tick();
    n_tests++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h4044424641454347) begin
      n_fail++; $display("FAIL sim_hold valid=%0b data=%016h exp=1/4044424641454347", frame_valid, frame_data);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL sim_drained got=%0b exp=0", frame_valid); end
    $display("[TB] simultaneous fill and drain");
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    int rx;
    int rv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    rx = 0;
    fork
      begin : producer
        logic [7:0]  nat[8];
        logic [63:0] e;
        for (int f = 0; f < 100; f++) begin
          for (int i = 0; i < 8; i++) begin
            while ($urandom_range(1, 0) == 1) tick();
            nat[i] = 8'($urandom_range(255, 0));
            if (i == 7) begin
              e = '0;
              for (int s = 0; s < 8; s++) e[8*(8-s)-1 -: 8] = nat[rv[s]];
              exp_q.push_back(e);
            end
            push(nat[i], i == 0);
          end
        end
      end
      begin : consumer
        int cyc;
        logic [63:0] e;
        cyc = 0;
        while (rx < 100 && cyc < 20000) begin
          frame_ready = 1'($urandom_range(1, 0));
          if (frame_valid && frame_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_unexpected frame=%016h exp=none", frame_data);
            end else begin
              e = exp_q.pop_front();
              if (frame_data !== e) begin
                n_fail++; $display("FAIL rand_frame idx=%0d got=%016h exp=%016h", rx, frame_data, e);
              end
            end
            rx++;
          end
          tick();
          cyc++;
        end
        frame_ready = 1'b0;
      end
    join
    n_tests++;
    if (rx != 100) begin n_fail++; $display("FAIL rand_count got=%0d exp=100", rx); end
    $display("[TB] random: %0d frames received", rx);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_partial_abort();
    test_reset_midframe();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
